imm_gen: RTL and testbench
==========================

// Module: imm_gen
// PURPOSE
// - RV32I immediate generator for the single-cycle/pipelined datapath decode stage.
// - Decodes the instruction format from the opcode, extracts the immediate and
//   sign-extends it to 32 bits for the ALU B-mux and the branch/jump adders.
// - The result is registered, which aligns it with the decode pipeline register.
// PARAMETERS
// - REG_OUT  1  1: outputs registered (1-cycle latency); 0: purely combinational (clk/reset unused)
// PORTS
// - clk           in   1   system clock, rising edge
// - reset         in   1   asynchronous, active-high reset
// - instrValid    in   1   instruction qualifier; capture only when high
// - instruction   in   32  raw RV32I instruction word
// - extImmediate  out  32  sign-extended immediate
// - immType       out  3   0=R/none 1=I 2=S 3=B 4=U 5=J 7=illegal
// - immValid      out  1   extImmediate/immType valid
// - illegal       out  1   opcode not in the supported table
// BEHAVIOUR
// - One clock (clk); reset is asynchronous and active-high. While reset is high:
//   extImmediate=0, immType=0, immValid=0, illegal=0. Outputs hold 0 until the first accepted capture.
// - REG_OUT=1: at posedge clk, immValid<=instrValid. When instrValid=1, all other outputs update
//   from the decode; when 0, extImmediate/immType/illegal hold their previous values. Latency 1 cycle.
// - REG_OUT=0: outputs follow the decode combinationally; immValid=instrValid.
// - Decode on opcode instruction[6:0]:
//   - 0000011 load, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM -> I: {{20{i[31]}}, i[31:20]}
//   - OP-IMM with funct3 001/101 (shifts) -> I, imm = {27'b0, i[24:20]} (shamt zero-extended)
//   - 0100011 store -> S: {{20{i[31]}}, i[31:25], i[11:7]}
//   - 1100011 branch -> B: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
//   - 0110111 LUI, 0010111 AUIPC -> U: {i[31:12], 12'b0}
//   - 1101111 JAL -> J: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
//   - 0110011 R-type -> imm 0, immType 0, illegal 0
//   - any other opcode -> imm 0, immType 7, illegal 1
// - Sign bit is always instruction[31] (except shifts); no other fields affect the result.
// - Bits [1:0] not equal to 2'b11 -> treat as illegal.
// - Reset asserted mid-stream clears the outputs immediately, without waiting for clk.
//   The first capture after deassertion is the next posedge with instrValid=1.
// CONFIGURATION
// - Macro IMM_GEN_UJ_EN.
//   - Defined: the U and J formats are decoded as above.
//   - Not defined: LUI/AUIPC/JAL give imm 0, immType 7, illegal 1; all other formats are unchanged.
// TESTING
// - LW 0x0F052483, instrValid=1 -> next cycle extImmediate=0x000000F0, immType=1, immValid=1
// - ADDI x1,x0,-1 0xFFF00093 -> 0xFFFFFFFF (I); SW x1,-4(x2) 0xFE112E23 -> 0xFFFFFFFC (S)
// - BEQ x0,x0,-8 0xFE000CE3 -> 0xFFFFFFF8 (B); SLLI shamt 31 0x01F09093 -> 0x0000001F
// - IMM_GEN_UJ_EN defined:
//   - LUI 0x123450B7 -> 0x12345000 (U)
//   - JAL x1,+2048 0x001000EF -> 0x00000800 (J)
// - IMM_GEN_UJ_EN undefined: the same LUI/JAL words -> 0, illegal=1, immType=7
// - Reset pulse between clock edges -> all outputs 0 at once; instrValid=0 cycles -> outputs hold, immValid=0

Source files
------------

// File: rtl/imm_gen.sv
// RV32I immediate generator: opcode-driven format decode, sign extension, optional output register.
// Build option IMM_GEN_UJ_EN enables LUI/AUIPC/JAL (U/J) decode; undefined, those opcodes decode as illegal.
module imm_gen #(
    parameter int REG_OUT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instrValid,
    input  logic [31:0] instruction,
    output logic [31:0] extImmediate,
    output logic [2:0]  immType,
    output logic        immValid,
    output logic        illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] TYPE_NONE    = 3'd0;
    localparam logic [2:0] TYPE_I       = 3'd1;
    localparam logic [2:0] TYPE_S       = 3'd2;
    localparam logic [2:0] TYPE_B       = 3'd3;
    localparam logic [2:0] TYPE_U       = 3'd4;
    localparam logic [2:0] TYPE_J       = 3'd5;
    localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_sign;
    logic [31:0] w_imm;
    logic [2:0]  w_type;
    logic        w_illegal;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_sign   = instruction[31];

    // Opcodes with bits [1:0] != 2'b11 never match a table entry, so they fall to illegal.
    always_comb begin
        w_imm     = 32'd0;
        w_type    = TYPE_ILLEGAL;
        w_illegal = 1'b1;
        case (w_opcode)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                w_imm     = {{20{w_sign}}, instruction[31:20]};
                w_type    = TYPE_I;
                w_illegal = 1'b0;
            end
            OPC_OPIMM: begin
                // Shift-immediates carry funct7 in the upper bits; only shamt is the operand.
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_imm = {27'd0, instruction[24:20]};
                end else begin
                    w_imm = {{20{w_sign}}, instruction[31:20]};
                end
                w_type    = TYPE_I;
                w_illegal = 1'b0;
            end
            OPC_STORE: begin
                w_imm     = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
                w_type    = TYPE_S;
                w_illegal = 1'b0;
            end
            OPC_BRANCH: begin
                w_imm     = {{19{w_sign}}, w_sign, instruction[7], instruction[30:25],
                             instruction[11:8], 1'b0};
                w_type    = TYPE_B;
                w_illegal = 1'b0;
            end
`ifdef IMM_GEN_UJ_EN
            OPC_LUI, OPC_AUIPC: begin
                w_imm     = {instruction[31:12], 12'd0};
                w_type    = TYPE_U;
                w_illegal = 1'b0;
            end
            OPC_JAL: begin
                w_imm     = {{11{w_sign}}, w_sign, instruction[19:12], instruction[20],
                             instruction[30:21], 1'b0};
                w_type    = TYPE_J;
                w_illegal = 1'b0;
            end
`endif
            OPC_OP: begin
                w_imm     = 32'd0;
                w_type    = TYPE_NONE;
                w_illegal = 1'b0;
            end
            default: begin
                w_imm     = 32'd0;
                w_type    = TYPE_ILLEGAL;
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [31:0] r_imm;
            logic [2:0]  r_type;
            logic        r_valid;
            logic        r_illegal;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_imm     <= 32'd0;
                    r_type    <= TYPE_NONE;
                    r_valid   <= 1'b0;
                    r_illegal <= 1'b0;
                end else begin
                    r_valid <= instrValid;
                    if (instrValid) begin
                        r_imm     <= w_imm;
                        r_type    <= w_type;
                        r_illegal <= w_illegal;
                    end
                end
            end

            assign extImmediate = r_imm;
            assign immType      = r_type;
            assign immValid     = r_valid;
            assign illegal      = r_illegal;
        end else begin : g_comb
            logic w_unused;
            assign w_unused     = clk ^ reset;
            assign extImmediate = w_imm;
            assign immType      = w_type;
            assign immValid     = instrValid;
            assign illegal      = w_illegal;
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen.sv
// Directed-vector bench for imm_gen: registered and combinational instances side by side.
module tb_imm_gen;

    logic        clk;
    logic        reset;
    logic        instrValid;
    logic [31:0] instruction;

    logic [31:0] r_imm, c_imm;
    logic [2:0]  r_type, c_type;
    logic        r_vld, c_vld;
    logic        r_ill, c_ill;

    int n_cmp = 0;
    int n_bad = 0;

    imm_gen #(.REG_OUT(1)) u_reg (
        .clk(clk), .reset(reset), .instrValid(instrValid), .instruction(instruction),
        .extImmediate(r_imm), .immType(r_type), .immValid(r_vld), .illegal(r_ill)
    );

    imm_gen #(.REG_OUT(0)) u_comb (
        .clk(clk), .reset(reset), .instrValid(instrValid), .instruction(instruction),
        .extImmediate(c_imm), .immType(c_type), .immValid(c_vld), .illegal(c_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one word, check the comb instance before the edge and the registered one after.
    task automatic vec(input string tag, input logic [31:0] ins, input logic [31:0] eimm,
                       input logic [2:0] etype, input logic eill);
        @(negedge clk);
        instruction = ins;
        instrValid  = 1'b1;
        #1;
        chk({tag, "_c_imm"}, c_imm, eimm);
        chk({tag, "_c_type"}, {29'd0, c_type}, {29'd0, etype});
        chk({tag, "_c_ill"}, {31'd0, c_ill}, {31'd0, eill});
        @(posedge clk);
        #1;
        chk({tag, "_imm"}, r_imm, eimm);
        chk({tag, "_type"}, {29'd0, r_type}, {29'd0, etype});
        chk({tag, "_ill"}, {31'd0, r_ill}, {31'd0, eill});
        chk({tag, "_vld"}, {31'd0, r_vld}, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_imm"}, r_imm, 32'd0);
        chk({tag, "_type"}, {29'd0, r_type}, 32'd0);
        chk({tag, "_vld"}, {31'd0, r_vld}, 32'd0);
        chk({tag, "_ill"}, {31'd0, r_ill}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        instrValid  = 1'b0;
        instruction = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("idle");

        vec("lw",    32'h0F05_2483, 32'h0000_00F0, 3'd1, 1'b0);
        vec("addi",  32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
        vec("sw",    32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 1'b0);
        vec("beq",   32'hFE00_0CE3, 32'hFFFF_FFF8, 3'd3, 1'b0);
        vec("slli",  32'h01F0_9093, 32'h0000_001F, 3'd1, 1'b0);
        vec("srai",  32'h4010_5093, 32'h0000_0001, 3'd1, 1'b0);
        vec("jalr",  32'hFFC0_80E7, 32'hFFFF_FFFC, 3'd1, 1'b0);
        vec("sys",   32'h8000_0073, 32'hFFFF_F800, 3'd1, 1'b0);
        vec("add",   32'h0020_81B3, 32'h0000_0000, 3'd0, 1'b0);
        vec("ill7f", 32'hFFFF_FFFF, 32'h0000_0000, 3'd7, 1'b1);
        vec("lowb",  32'h0000_0091, 32'h0000_0000, 3'd7, 1'b1);
`ifdef IMM_GEN_UJ_EN
        vec("lui",   32'h1234_50B7, 32'h1234_5000, 3'd4, 1'b0);
        vec("auipc", 32'h8000_0297, 32'h8000_0000, 3'd4, 1'b0);
        vec("jal",   32'h0010_00EF, 32'h0000_0800, 3'd5, 1'b0);
`else
        vec("lui",   32'h1234_50B7, 32'h0000_0000, 3'd7, 1'b1);
        vec("auipc", 32'h8000_0297, 32'h0000_0000, 3'd7, 1'b1);
        vec("jal",   32'h0010_00EF, 32'h0000_0000, 3'd7, 1'b1);
`endif
        // Load a distinctive value, then drop instrValid: data holds, valid falls.
        vec("addi2", 32'h7FF0_0093, 32'h0000_07FF, 3'd1, 1'b0);
        @(negedge clk);
        instrValid  = 1'b0;
        instruction = 32'hFE11_2E23;
        #1;
        chk("c_vld_low", {31'd0, c_vld}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("hold_imm", r_imm, 32'h0000_07FF);
            chk("hold_type", {29'd0, r_type}, 32'd1);
            chk("hold_vld", {31'd0, r_vld}, 32'd0);
        end

        vec("beq2", 32'hFE00_0CE3, 32'hFFFF_FFF8, 3'd3, 1'b0);
        // Asynchronous reset pulse between edges.
        @(negedge clk);
        instrValid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_zero("async");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("postrst");
        vec("lw2", 32'h0F05_2483, 32'h0000_00F0, 3'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
